// File: rtl/latch_id_ex_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | latch_id_ex_if : ID/EX bus (stage controls, decode in, EX out)      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface latch_id_ex_if #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_FUNCT = 6
);
  logic                i_step, i_flush;
  logic                i_reg_dst_rd, i_jump, i_jal, i_branch, i_new_branch;
  logic                i_mem_read, i_mem_to_reg, i_mem_write, i_alu_src, i_reg_write;
  logic                i_zero_extend, i_lui, i_jalR, i_halt;
  logic [1:0]          i_alu_op, i_extension_mode, i_size_filter, i_size_filterL;
  logic [NB_DATA-1:0]  i_pc4, i_pc8, i_data_ra, i_data_rb, i_extension;
  logic [NB_ADDR-1:0]  i_rs, i_rt, i_rd;
  logic [NB_FUNCT-1:0] i_funct;

  logic                o_reg_dst_rd, o_jump, o_jal, o_branch, o_new_branch;
  logic                o_mem_read, o_mem_to_reg, o_mem_write, o_alu_src, o_reg_write;
  logic                o_zero_extend, o_lui, o_jalR, o_halt;
  logic [1:0]          o_alu_op, o_extension_mode, o_size_filter, o_size_filterL;
  logic [NB_DATA-1:0]  o_pc4, o_pc8, o_data_ra, o_data_rb, o_extension;
  logic [NB_ADDR-1:0]  o_rs, o_rt, o_rd;
  logic [NB_FUNCT-1:0] o_funct;
  logic                o_valid, o_halt_seen;

  modport master (
    output i_step, i_flush,
    output i_reg_dst_rd, i_jump, i_jal, i_branch, i_new_branch,
    output i_mem_read, i_mem_to_reg, i_mem_write, i_alu_src, i_reg_write,
    output i_zero_extend, i_lui, i_jalR, i_halt,
    output i_alu_op, i_extension_mode, i_size_filter, i_size_filterL,
    output i_pc4, i_pc8, i_data_ra, i_data_rb, i_extension, i_rs, i_rt, i_rd, i_funct,
    input  o_reg_dst_rd, o_jump, o_jal, o_branch, o_new_branch,
    input  o_mem_read, o_mem_to_reg, o_mem_write, o_alu_src, o_reg_write,
    input  o_zero_extend, o_lui, o_jalR, o_halt,
    input  o_alu_op, o_extension_mode, o_size_filter, o_size_filterL,
    input  o_pc4, o_pc8, o_data_ra, o_data_rb, o_extension, o_rs, o_rt, o_rd, o_funct,
    input  o_valid, o_halt_seen
  );

  modport slave (
    input  i_step, i_flush,
    input  i_reg_dst_rd, i_jump, i_jal, i_branch, i_new_branch,
    input  i_mem_read, i_mem_to_reg, i_mem_write, i_alu_src, i_reg_write,
    input  i_zero_extend, i_lui, i_jalR, i_halt,
    input  i_alu_op, i_extension_mode, i_size_filter, i_size_filterL,
    input  i_pc4, i_pc8, i_data_ra, i_data_rb, i_extension, i_rs, i_rt, i_rd, i_funct,
    output o_reg_dst_rd, o_jump, o_jal, o_branch, o_new_branch,
    output o_mem_read, o_mem_to_reg, o_mem_write, o_alu_src, o_reg_write,
    output o_zero_extend, o_lui, o_jalR, o_halt,
    output o_alu_op, o_extension_mode, o_size_filter, o_size_filterL,
    output o_pc4, o_pc8, o_data_ra, o_data_rb, o_extension, o_rs, o_rt, o_rd, o_funct,
    output o_valid, o_halt_seen
  );
endinterface
`default_nettype wire

// File: rtl/latch_id_ex.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | latch_id_ex : ID/EX pipeline register with hold, flush, halt flag   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module latch_id_ex #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_FUNCT = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  latch_id_ex_if.slave  bus
);
  localparam int C_NB_CTRL = 22;
  localparam int C_NB_DBUS = 5*NB_DATA + 3*NB_ADDR + NB_FUNCT;

  logic [C_NB_CTRL-1:0] w_ctrl, r_ctrl;
  logic [C_NB_DBUS-1:0] w_data, r_data;
  logic                 w_live;
  logic                 r_valid, r_halt_seen;

  assign w_ctrl = {bus.i_reg_dst_rd, bus.i_jump, bus.i_jal, bus.i_branch, bus.i_new_branch,
                   bus.i_mem_read, bus.i_mem_to_reg, bus.i_mem_write, bus.i_alu_src,
                   bus.i_reg_write, bus.i_zero_extend, bus.i_lui, bus.i_jalR, bus.i_halt,
                   bus.i_alu_op, bus.i_extension_mode, bus.i_size_filter, bus.i_size_filterL};

  assign w_data = {bus.i_pc4, bus.i_pc8, bus.i_data_ra, bus.i_data_rb, bus.i_extension,
                   bus.i_rs, bus.i_rt, bus.i_rd, bus.i_funct};

  // Only controls with an architectural side effect mark the slot as a real instruction.
  assign w_live = bus.i_reg_write | bus.i_mem_write | bus.i_branch | bus.i_new_branch |
                  bus.i_jump | bus.i_jal | bus.i_jalR | bus.i_halt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ctrl      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_halt_seen <= 1'b0;
    end else if (bus.i_step) begin
      if (bus.i_flush) begin
        r_ctrl  <= '0;
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ctrl      <= w_ctrl;
        r_data      <= w_data;
        r_valid     <= w_live;
        r_halt_seen <= r_halt_seen | bus.i_halt;
      end
    end
  end

  assign {bus.o_reg_dst_rd, bus.o_jump, bus.o_jal, bus.o_branch, bus.o_new_branch,
          bus.o_mem_read, bus.o_mem_to_reg, bus.o_mem_write, bus.o_alu_src,
          bus.o_reg_write, bus.o_zero_extend, bus.o_lui, bus.o_jalR, bus.o_halt,
          bus.o_alu_op, bus.o_extension_mode, bus.o_size_filter, bus.o_size_filterL} = r_ctrl;

  assign {bus.o_pc4, bus.o_pc8, bus.o_data_ra, bus.o_data_rb, bus.o_extension,
          bus.o_rs, bus.o_rt, bus.o_rd, bus.o_funct} = r_data;

  assign bus.o_valid     = r_valid;
  assign bus.o_halt_seen = r_halt_seen;
endmodule
`default_nettype wire
